instr_trip_unit: RTL
====================

Name: instr_trip_unit

Overview:
Parametrised, clocked successor to the per-channel trip evaluation in the instrumentation unit. It accepts a vector of sensor samples and setpoints through a valid/ready handshake and compares each channel with a per-channel signedness and direction. Trips are debounced over N consecutive samples and latched per channel under mode control (bypass/operate/manual trip). Results are presented to the voting logic through a backpressured output register.

Parameters:
NChannels, 3, number of sensor channels
W, 32, sample/setpoint width in bits
DebounceLen, 2, consecutive exceeding samples required to assert a sensor trip (>=1)
CntW, $clog2(DebounceLen+1), debounce counter width (derived, localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  vals/setpoints valid
sample_ready  out  1  unit can accept a sample this cycle
vals  in  NChannels*W  channel 0 in MSBs (channel i at [W*(NChannels-i-1)+W-1 -: W])
setpoints  in  NChannels*W  same packing as vals
cmp_signed  in  NChannels  1 = signed compare for channel i, 0 = unsigned
cmp_low  in  NChannels  1 = trip when v < sp; 0 = trip when sp < v
mode  in  NChannels*2  per-channel mode, channel i at [2*(NChannels-i-1)+1 -: 2]
reset_trip  in  NChannels  per-channel latch clear request (level)
out_valid  out  1  sensor_trip/raw_exceed hold a fresh result
out_ready  in  1  consumer takes the result
raw_exceed  out  NChannels  undebounced comparison of last accepted sample
sensor_trip  out  NChannels  debounced trip per channel
ch_tripped  out  NChannels  latched channel trip (bit NChannels-1-i = channel i)

Behaviour:
- Reset (async, rst_n=0): out_valid=0, raw_exceed=0, sensor_trip=0, ch_tripped=0, all debounce counters=0. sample_ready=1 once out of reset.
- Handshake: sample_ready = ~out_valid | out_ready (combinational). Accept = sample_valid & sample_ready.
- On accept (cycle t), registered at edge ending t: raw_exceed[i] = cmp_low[i] ? (v<sp) : (sp<v), with signedness per cmp_signed[i]; equality never trips.
- Debounce per channel on accept: exceed -> cnt = min(cnt+1, DebounceLen) (saturates, no wrap); else cnt = 0. sensor_trip[i] = (cnt_next == DebounceLen). Counters and outputs are unchanged when there is no accept.
- out_valid: set by accept, cleared by out_ready without accept, held otherwise. Latency: result visible cycle t+1. Simultaneous out_ready & accept: out_valid stays 1 with new data (full throughput).
- Modes (package enum): 0 BYPASS, 1 OPERATE, 2 MANUAL_TRIP, 3 reserved, treated as MANUAL_TRIP (fail-safe).
- Latch (evaluated every cycle, independent of handshake): BYPASS -> 0; MANUAL_TRIP -> 1; OPERATE -> set if sensor_trip_next[i], else cleared if reset_trip[i], else hold. Set wins over reset_trip.
- Mode change mid-stream takes effect next edge; debounce counters are not affected by mode.
- Reset mid-operation discards the pending result; no partial state survives.

Decomposition:
- Package instr_pkg: trip_mode_t enum (BYPASS, OPERATE, MANUAL_TRIP, RESERVED), mode width constant, channel-slice helper function.
- Sub-module instr_trip_channel (one per channel, generate loop): compare, debounce counter, latch. The top level holds the handshake and out_valid register only.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, sample_ready=1 after release.
- Unsigned high trip, ch0 OPERATE, DebounceLen=2, sp=100: samples v=101,101 -> sensor_trip[ch0]=0 then 1, ch_tripped[ch0]=1 at second result; v=100 -> raw_exceed=0, counter cleared, latch held.
- Signed low trip, ch2 cmp_signed=1 cmp_low=1, sp=0: v=32'hFFFF_FFFF (-1) x2 -> trip; unsigned same config -> no trip.
- Debounce break: exceed, normal, exceed -> sensor_trip never asserts; 5 consecutive exceeds -> counter saturates at 2, stays asserted.
- Latch/mode: latched ch1 with reset_trip=1 while still exceeding -> stays 1; after normal sample -> clears; mode=2 with no samples -> ch_tripped=1 next cycle; mode=0 -> 0; mode=3 -> 1.
- Backpressure: out_ready=0 with sample_valid=1 -> one accept, then sample_ready=0, outputs stable; out_ready=1 with sample_valid=1 -> back-to-back accepts every cycle.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared types and helpers for the instrumentation trip unit.
package instr_pkg;
    localparam int ModeW = 2;

    typedef enum logic [ModeW-1:0] {
        BYPASS      = 2'd0,
        OPERATE     = 2'd1,
        MANUAL_TRIP = 2'd2,
        RESERVED    = 2'd3
    } trip_mode_t;

    // LSB position of channel ch in a bus of n fields of width w, channel 0 in the MSBs.
    function automatic int ch_lsb(input int ch, input int n, input int w);
        return w * (n - ch - 1);
    endfunction
endpackage

// File: rtl/instr_trip_channel.sv
// One sensor channel: configurable compare, saturating debounce counter and trip latch.
module instr_trip_channel
    import instr_pkg::*;
#(
    parameter int W           = 32,
    parameter int DebounceLen = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         accept,
    input  logic [W-1:0] v,
    input  logic [W-1:0] sp,
    input  logic         is_signed,
    input  logic         low,
    input  trip_mode_t   mode,
    input  logic         reset_trip,
    output logic         raw_exceed,
    output logic         sensor_trip,
    output logic         tripped
);
    localparam int CntW = $clog2(DebounceLen + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceLen);

    logic [CntW-1:0] cnt, cnt_next;
    logic            exceed, trip_next, latch_next;

    always_comb begin
        if (is_signed) exceed = low ? ($signed(v) < $signed(sp)) : ($signed(sp) < $signed(v));
        else           exceed = low ? (v < sp) : (sp < v);
        cnt_next  = exceed ? ((cnt == CntMax) ? cnt : cnt + 1'b1) : '0;
        // Without an accept the debounced trip simply holds its last value.
        trip_next = accept ? (cnt_next == CntMax) : sensor_trip;
        case (mode)
            BYPASS:  latch_next = 1'b0;
            OPERATE: latch_next = trip_next ? 1'b1 : (reset_trip ? 1'b0 : tripped);
            default: latch_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            raw_exceed  <= 1'b0;
            sensor_trip <= 1'b0;
            tripped     <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= cnt_next;
                raw_exceed  <= exceed;
                sensor_trip <= trip_next;
            end
            tripped <= latch_next;
        end
    end
endmodule

// File: rtl/instr_trip_unit.sv
// Multi-channel trip evaluation with valid/ready input and a backpressured result register.
// All per-channel vectors put channel i at bit NChannels-1-i, matching the packed buses.
module instr_trip_unit
    import instr_pkg::*;
#(
    parameter int NChannels   = 3,
    parameter int W           = 32,
    parameter int DebounceLen = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [NChannels*W-1:0]   vals,
    input  logic [NChannels*W-1:0]   setpoints,
    input  logic [NChannels-1:0]     cmp_signed,
    input  logic [NChannels-1:0]     cmp_low,
    input  logic [NChannels*2-1:0]   mode,
    input  logic [NChannels-1:0]     reset_trip,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NChannels-1:0]     raw_exceed,
    output logic [NChannels-1:0]     sensor_trip,
    output logic [NChannels-1:0]     ch_tripped
);
    logic accept;

    assign sample_ready = ~out_valid | out_ready;
    assign accept       = sample_valid & sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_valid <= 1'b0;
        else if (accept)    out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    for (genvar i = 0; i < NChannels; i++) begin : g_ch
        localparam int B  = NChannels - 1 - i;
        localparam int VL = ch_lsb(i, NChannels, W);
        localparam int ML = ch_lsb(i, NChannels, ModeW);

        instr_trip_channel #(.W(W), .DebounceLen(DebounceLen)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .accept      (accept),
            .v           (vals[VL +: W]),
            .sp          (setpoints[VL +: W]),
            .is_signed   (cmp_signed[B]),
            .low         (cmp_low[B]),
            .mode        (trip_mode_t'(mode[ML +: ModeW])),
            .reset_trip  (reset_trip[B]),
            .raw_exceed  (raw_exceed[B]),
            .sensor_trip (sensor_trip[B]),
            .tripped     (ch_tripped[B])
        );
    end
endmodule
